// File: rtl/pss_ctrl_pkg.sv
// Shared types and helpers for the PSS search controller.
package pss_ctrl_pkg;

  localparam int N_ID_2_NUM = 3;
  localparam int ARG_DW     = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    TRACK  = 2'd2
  } state_t;

  // Strict > means an equal later candidate never displaces an earlier one.
  function automatic logic [1:0] argmax3(input logic [ARG_DW-1:0] v0,
                                         input logic [ARG_DW-1:0] v1,
                                         input logic [ARG_DW-1:0] v2);
    logic [1:0]        idx;
    logic [ARG_DW-1:0] best;
    idx  = 2'd0;
    best = v0;
    if (v1 > best) begin
      idx  = 2'd1;
      best = v1;
    end
    if (v2 > best) begin
      idx = 2'd2;
    end
    return idx;
  endfunction

endpackage

// File: rtl/pss_peak_hold.sv
// Windowed max-and-position holder; outputs already include the sample presented this cycle.
module pss_peak_hold #(
  parameter int DW = 24,
  parameter int PW = 17
) (
  input  logic          clk_i,
  input  logic          reset_ni,
  input  logic          clear_i,
  input  logic          sample_i,
  input  logic [DW-1:0] value_i,
  input  logic [PW-1:0] pos_i,
  output logic [DW-1:0] max_o,
  output logic [PW-1:0] max_pos_o
);

  logic [DW-1:0] r_max;
  logic [PW-1:0] r_max_pos;
  logic          w_take;

  assign w_take    = sample_i && (value_i > r_max);
  assign max_o     = w_take ? value_i : r_max;
  assign max_pos_o = w_take ? pos_i   : r_max_pos;

  // Clear wins over sample so the closing sample is seen by max_o but not kept.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_max     <= '0;
      r_max_pos <= '0;
    end else if (clear_i) begin
      r_max     <= '0;
      r_max_pos <= '0;
    end else if (w_take) begin
      r_max     <= value_i;
      r_max_pos <= pos_i;
    end
  end

endmodule

// File: rtl/pss_search_ctrl.sv
// Cell-search sequencer over three PSS correlators: free-running SEARCH, windowed TRACK lock.
// Optional macro PSS_CTRL_STATS_EN adds saturating det_cnt_o / lost_cnt_o counters.
module pss_search_ctrl
  import pss_ctrl_pkg::*;
#(
  parameter int C_DW       = 24,
  parameter int SSB_PERIOD = 76800,
  parameter int WINDOW     = 8,
  parameter int MISS_LIMIT = 3
) (
  input  logic                         clk_i,
  input  logic                         reset_ni,
  input  logic                         enable_i,
  input  logic [C_DW-1:0]              thr_i,
  input  logic [N_ID_2_NUM*C_DW-1:0]   corr_i,
  input  logic                         corr_valid_i,
  output logic                         peak_valid_o,
  output logic [1:0]                   n_id_2_o,
  output logic [$clog2(SSB_PERIOD)-1:0] peak_pos_o,
  output logic                         locked_o,
  output logic                         window_o,
  output logic                         lost_o
`ifdef PSS_CTRL_STATS_EN
  ,
  output logic [15:0]                  det_cnt_o,
  output logic [15:0]                  lost_cnt_o
`endif
);

  localparam int POS_DW  = $clog2(SSB_PERIOD);
  localparam int MISS_DW = $clog2(MISS_LIMIT + 1);

  localparam logic [POS_DW-1:0]  LP_POS_ONE  = POS_DW'(1);
  localparam logic [POS_DW-1:0]  LP_LAST     = POS_DW'(SSB_PERIOD - 1);
  localparam logic [POS_DW-1:0]  LP_WIN      = POS_DW'(WINDOW);
  localparam logic [POS_DW-1:0]  LP_WIN_LO   = POS_DW'(SSB_PERIOD - WINDOW);
  localparam logic [POS_DW-1:0]  LP_WRAP     = POS_DW'(SSB_PERIOD + WINDOW);
  localparam logic [MISS_DW-1:0] LP_MISS_ONE = MISS_DW'(1);
  localparam logic [MISS_DW-1:0] LP_MISS_TOP = MISS_DW'(MISS_LIMIT - 1);

  state_t              r_state, w_state_nxt;
  logic [POS_DW-1:0]   r_pos, w_pos_nxt, w_pos_inc;
  logic                r_armed, w_armed_nxt;
  logic [MISS_DW-1:0]  r_miss, w_miss_nxt;
  logic                r_peak_valid, w_peak_valid_nxt;
  logic [1:0]          r_n_id_2, w_n_id_2_nxt;
  logic [POS_DW-1:0]   r_peak_pos, w_peak_pos_nxt;
  logic                r_lost, w_lost_nxt;

  logic [C_DW-1:0]     w_corr [N_ID_2_NUM];
  logic [1:0]          w_lead_idx;
  logic [C_DW-1:0]     w_lead_val;
  logic [C_DW-1:0]     w_trk_val;
  logic                w_in_win;
  logic                w_open;
  logic                w_close;
  logic                w_hold_sample;
  logic                w_hold_clear;
  logic [C_DW-1:0]     w_hold_max;
  logic [POS_DW-1:0]   w_hold_pos;
  logic [POS_DW-1:0]   w_realign;

  for (genvar k = 0; k < N_ID_2_NUM; k++) begin : g_corr
    assign w_corr[k] = corr_i[k*C_DW +: C_DW];
  end

  assign w_lead_idx = argmax3(ARG_DW'(w_corr[0]), ARG_DW'(w_corr[1]), ARG_DW'(w_corr[2]));

  always_comb begin
    w_lead_val = w_corr[0];
    w_trk_val  = w_corr[0];
    case (w_lead_idx)
      2'd1:    w_lead_val = w_corr[1];
      2'd2:    w_lead_val = w_corr[2];
      default: w_lead_val = w_corr[0];
    endcase
    case (r_n_id_2)
      2'd1:    w_trk_val = w_corr[1];
      2'd2:    w_trk_val = w_corr[2];
      default: w_trk_val = w_corr[0];
    endcase
  end

  // r_pos is the position of the last accepted sample; the incoming one sits at w_pos_inc.
  assign w_pos_inc = (r_pos == LP_LAST) ? '0 : r_pos + LP_POS_ONE;
  assign w_in_win  = (w_pos_inc >= LP_WIN_LO) || (w_pos_inc <= LP_WIN);
  assign w_open    = (w_pos_inc == LP_WIN_LO);

  // A window only closes after it was opened, so the partial windows after lock/re-align never count.
  assign w_hold_sample = enable_i && corr_valid_i && (r_state == TRACK)
                         && (r_armed || w_open) && w_in_win;
  assign w_close       = enable_i && corr_valid_i && (r_state == TRACK)
                         && r_armed && (w_pos_inc == LP_WIN);
  assign w_hold_clear  = w_close || !enable_i;

  pss_peak_hold #(
    .DW (C_DW),
    .PW (POS_DW)
  ) u_peak_hold (
    .clk_i     (clk_i),
    .reset_ni  (reset_ni),
    .clear_i   (w_hold_clear),
    .sample_i  (w_hold_sample),
    .value_i   (w_trk_val),
    .pos_i     (w_pos_inc),
    .max_o     (w_hold_max),
    .max_pos_o (w_hold_pos)
  );

  // Map the held peak back to 0: the closing sample lands at WINDOW minus the peak's signed offset.
  assign w_realign = (w_hold_pos <= LP_WIN) ? (LP_WIN - w_hold_pos) : (LP_WRAP - w_hold_pos);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_pos_nxt        = r_pos;
    w_armed_nxt      = r_armed;
    w_miss_nxt       = r_miss;
    w_peak_valid_nxt = 1'b0;
    w_lost_nxt       = 1'b0;
    w_n_id_2_nxt     = r_n_id_2;
    w_peak_pos_nxt   = r_peak_pos;

    if (!enable_i) begin
      w_state_nxt    = IDLE;
      w_pos_nxt      = '0;
      w_armed_nxt    = 1'b0;
      w_miss_nxt     = '0;
      w_n_id_2_nxt   = 2'd0;
      w_peak_pos_nxt = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt = SEARCH;
        end
        SEARCH: begin
          if (corr_valid_i && (w_lead_val > thr_i)) begin
            w_state_nxt      = TRACK;
            w_peak_valid_nxt = 1'b1;
            w_n_id_2_nxt     = w_lead_idx;
            w_peak_pos_nxt   = '0;
            w_pos_nxt        = '0;
            w_armed_nxt      = 1'b0;
            w_miss_nxt       = '0;
          end
        end
        TRACK: begin
          if (corr_valid_i) begin
            w_pos_nxt = w_pos_inc;
            if (w_open) begin
              w_armed_nxt = 1'b1;
            end
            if (w_close) begin
              w_armed_nxt = 1'b0;
              if (w_hold_max > thr_i) begin
                w_peak_valid_nxt = 1'b1;
                w_peak_pos_nxt   = w_hold_pos;
                w_miss_nxt       = '0;
                w_pos_nxt        = w_realign;
              end else if (r_miss == LP_MISS_TOP) begin
                w_lost_nxt     = 1'b1;
                w_miss_nxt     = '0;
                w_state_nxt    = SEARCH;
                w_pos_nxt      = '0;
                w_peak_pos_nxt = '0;
              end else begin
                w_miss_nxt = r_miss + LP_MISS_ONE;
              end
            end
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_pos        <= '0;
      r_armed      <= 1'b0;
      r_miss       <= '0;
      r_peak_valid <= 1'b0;
      r_n_id_2     <= 2'd0;
      r_peak_pos   <= '0;
      r_lost       <= 1'b0;
    end else begin
      r_pos        <= w_pos_nxt;
      r_armed      <= w_armed_nxt;
      r_miss       <= w_miss_nxt;
      r_peak_valid <= w_peak_valid_nxt;
      r_n_id_2     <= w_n_id_2_nxt;
      r_peak_pos   <= w_peak_pos_nxt;
      r_lost       <= w_lost_nxt;
    end
  end

  assign peak_valid_o = r_peak_valid;
  assign n_id_2_o     = r_n_id_2;
  assign peak_pos_o   = r_peak_pos;
  assign lost_o       = r_lost;
  assign locked_o     = (r_state == TRACK);
  assign window_o     = (r_state == TRACK) && ((r_pos >= LP_WIN_LO) || (r_pos <= LP_WIN));

`ifdef PSS_CTRL_STATS_EN
  logic        r_en_d;
  logic [15:0] r_det_cnt;
  logic [15:0] r_lost_cnt;
  logic        w_en_rise;

  assign w_en_rise = enable_i && !r_en_d;

  // Counters follow the registered pulses and restart on every enable rising edge.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_en_d     <= 1'b0;
      r_det_cnt  <= '0;
      r_lost_cnt <= '0;
    end else begin
      r_en_d <= enable_i;
      if (w_en_rise) begin
        r_det_cnt  <= '0;
        r_lost_cnt <= '0;
      end else begin
        if (r_peak_valid && (r_det_cnt != 16'hFFFF)) begin
          r_det_cnt <= r_det_cnt + 16'd1;
        end
        if (r_lost && (r_lost_cnt != 16'hFFFF)) begin
          r_lost_cnt <= r_lost_cnt + 16'd1;
        end
      end
    end
  end

  assign det_cnt_o  = r_det_cnt;
  assign lost_cnt_o = r_lost_cnt;
`endif

endmodule
